// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS BCD stopwatch advanced by an asynchronous divided tick.
// tick_in is synchronized and edge-detected; start_stop toggles IDLE/RUN/PAUSE;
// clear forces IDLE and zeroes the time and prescaler; rollover pulses on
// the 59:59 -> 00:00 wrap.
module stopwatch_bcd #(
  parameter int unsigned TICKS_PER_SEC = 1  // tick_in rises per second, 1..255
) (
  input  logic       clk,
  input  logic       rst,         // asynchronous, active low
  input  logic       tick_in,     // asynchronous to clk
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_SEC - 1);

  state_e     state_q, state_d;
  logic       tick_s1_q, tick_s1_d;
  logic       tick_s2_q, tick_s2_d;
  logic       tick_prev_q, tick_prev_d;
  logic       ss_prev_q, ss_prev_d;
  logic       clr_prev_q, clr_prev_d;
  logic [7:0] presc_q, presc_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       running_q, running_d;
  logic       rollover_q, rollover_d;

  logic tick_pulse;
  logic ss_edge;
  logic clr_edge;

  assign tick_pulse = tick_s2_q & ~tick_prev_q;
  assign ss_edge    = start_stop & ~ss_prev_q;
  assign clr_edge   = clear & ~clr_prev_q;

  // Next-state: synchronizer/edge shift, FSM transitions, prescaler and BCD carry chain.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    presc_d     = presc_q;
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    rollover_d  = 1'b0;
    tick_s1_d   = tick_in;
    tick_s2_d   = tick_s1_q;
    tick_prev_d = tick_s2_q;
    ss_prev_d   = start_stop;
    clr_prev_d  = clear;

    if (clr_edge) begin
      // Clear wins over a coincident start_stop edge or tick pulse.
      state_d    = S_IDLE;
      presc_d    = 8'd0;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else begin
      // Counting keys off the pre-transition state: a tick coincident with
      // RUN->PAUSE counts, one coincident with IDLE/PAUSE->RUN does not.
      if (state_q == S_RUN && tick_pulse) begin
        if (presc_q >= PRESC_MAX) begin
          presc_d = 8'd0;
          // Comparisons use >= so a corrupted digit still wraps back into range.
          if (sec_ones_q >= 4'd9) begin
            sec_ones_d = 4'd0;
            if (sec_tens_q >= 4'd5) begin
              sec_tens_d = 4'd0;
              if (min_ones_q >= 4'd9) begin
                min_ones_d = 4'd0;
                if (min_tens_q >= 4'd5) begin
                  min_tens_d = 4'd0;
                  rollover_d = 1'b1;
                end else begin
                  min_tens_d = min_tens_q + 4'd1;
                end
              end else begin
                min_ones_d = min_ones_q + 4'd1;
              end
            end else begin
              sec_tens_d = sec_tens_q + 4'd1;
            end
          end else begin
            sec_ones_d = sec_ones_q + 4'd1;
          end
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end

      if (ss_edge) begin
        unique case (state_q)
          S_IDLE:  state_d = S_RUN;
          S_RUN:   state_d = S_PAUSE;
          S_PAUSE: state_d = S_RUN;
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Registered copy of "in RUN" so running tracks state_q exactly.
    running_d = (state_d == S_RUN);
  end

  // State register: all flops cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tick_s1_q   <= 1'b0;
      tick_s2_q   <= 1'b0;
      tick_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      clr_prev_q  <= 1'b0;
      presc_q     <= 8'd0;
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 4'd0;
      running_q   <= 1'b0;
      rollover_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, like real registers.
      state_q     <= state_d;
      tick_s1_q   <= tick_s1_d;
      tick_s2_q   <= tick_s2_d;
      tick_prev_q <= tick_prev_d;
      ss_prev_q   <= ss_prev_d;
      clr_prev_q  <= clr_prev_d;
      presc_q     <= presc_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      running_q   <= running_d;
      rollover_q  <= rollover_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign running  = running_q;
  assign rollover = rollover_q;

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 1, meaning the number of tick_in rising edges per seconds increment (legal 1..255).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset: rst=0 resets immediately, independent of clk.
REQ-004 The block SHALL have port tick_in, input, 1, divided clock from the clock divisor stage, asynchronous to clk.
REQ-005 The block SHALL have port start_stop, input, 1, toggle request, synchronous to clk, acted on at its rising edge.
REQ-006 The block SHALL have port clear, input, 1, clear request, synchronous to clk, acted on at its rising edge.
REQ-007 The block SHALL have output port sec_ones, 4, BCD seconds units, range 0-9.
REQ-008 The block SHALL have output port sec_tens, 4, BCD seconds tens, range 0-5.
REQ-009 The block SHALL have output port min_ones, 4, BCD minutes units, range 0-9.
REQ-010 The block SHALL have output port min_tens, 4, BCD minutes tens, range 0-5.
REQ-011 The block SHALL have output port running, 1, high while the FSM is in RUN.
REQ-012 The block SHALL have output port rollover, 1, one-cycle pulse on the 59:59 -> 00:00 wrap.

Function
REQ-013 tick_in SHALL pass through a 2-flop synchronizer followed by a previous-value flop; tick_pulse = sync2 AND NOT prev.
REQ-014 A tick_in rise held for at least 3 clk cycles SHALL produce exactly one tick_pulse; counters update on the 3rd rising clk edge after tick_in rises.
REQ-015 start_stop and clear SHALL each be rising-edge detected with one registered copy; a held level SHALL act only once.
REQ-016 The FSM SHALL have states IDLE, RUN, PAUSE.
REQ-017 Transitions on a start_stop edge SHALL be: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-018 A clear edge in any state SHALL force IDLE, zero all four digits, and zero the prescaler on the same clk edge.
REQ-019 Clear SHALL take priority over a simultaneous start_stop edge and over a simultaneous tick_pulse.
REQ-020 The 8-bit prescaler SHALL advance only on tick_pulse in RUN.
REQ-021 When the prescaler equals TICKS_PER_SEC-1 on a tick_pulse, it SHALL return to 0 and the time SHALL advance by one second.
REQ-022 Digit carry chain:
  - sec_ones 9->0 carries into sec_tens;
  - sec_tens 5->0 carries into min_ones;
  - min_ones 9->0 carries into min_tens;
  - min_tens 5->0 wraps.
REQ-023 Advancing from 59:59 SHALL yield 00:00, keep the FSM in RUN, and assert rollover for exactly one cycle.
REQ-024 A tick_pulse coincident with a start_stop edge SHALL be handled according to the pre-transition state: RUN->PAUSE counts it; PAUSE->RUN and IDLE->RUN ignore it.
REQ-025 In IDLE and PAUSE, digits and prescaler SHALL hold.
REQ-026 All outputs SHALL be registered; digits SHALL never hold a non-BCD or out-of-range value.

Reset
REQ-027 On rst=0, all of the following SHALL be 0 asynchronously: digits, prescaler, synchronizer and edge-detect flops, running, and rollover; the FSM SHALL be in IDLE.
REQ-028 After rst returns to 1, the first start_stop edge SHALL start from 00:00.
REQ-029 rst asserted mid-count SHALL abandon the count with no residual prescaler value.

Verification
REQ-030 Basic count: rst pulse; start_stop edge; 5 tick_in rises (TICKS_PER_SEC=1) -> 00:05, running=1.
REQ-031 Pause and resume: pause at 00:05; 3 ticks -> still 00:05; resume; 1 tick -> 00:06.
REQ-032 Carries and wrap:
  - preload via 59 ticks -> 00:59; next tick -> 01:00;
  - run to 59:59; next tick -> 00:00 with a one-cycle rollover.
REQ-033 Coincident events:
  - clear, start_stop and tick_pulse in the same cycle -> IDLE, 00:00;
  - start_stop edge coincident with tick_pulse from RUN -> PAUSE with the tick counted.
REQ-034 Synchronizer:
  - tick_in high for 1 clk cycle -> 0 or 1 increments, never 2;
  - tick_in held high for 100 cycles -> exactly 1 increment.
REQ-035 Mid-operation reset: rst low at 12:34 during RUN -> outputs 0 before the next clk edge; TICKS_PER_SEC=4 -> 4 ticks per second.
